wb_mem_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter sharing the single-port banked memory between instruction fetch (m0) and load/store (m1).
- Registered grant with round-robin on contention; grant locked for a master's entire cyc_i burst.
- Watchdog per transfer: a slave that never acks yields err_o to the owning master instead of a hang.
- Sits between the core's two bus masters and the memory slave.

---
 rtl/wb_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of the shared memory slave.
// Round-robin grant locked for a whole cyc burst, with a no-ack watchdog.
module wb_mem_arbiter #(
  parameter int ADR_W   = 30,
  parameter int TIMEOUT = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  output logic [31:0]      m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  output logic [31:0]      m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [3:0]       s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_ON = (TIMEOUT > 0);
  localparam logic [CW-1:0] WD_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]    state;
  logic          own;
  logic          last;
  logic [CW-1:0] wd;
  logic [1:0]    err_q;

  logic ocyc;
  logic ostb;
  logic wd_exp;
  logic g0;
  logic g1;

  assign ocyc = own ? m1_cyc_i : m0_cyc_i;
  assign ostb = own ? m1_stb_i : m0_stb_i;

  // ack in the same cycle as expiry wins over the error
  assign wd_exp = WD_ON && ostb && !s_ack_i && (wd == WD_MAX);

  assign g0 = m0_cyc_i && (!m1_cyc_i || last);
  assign g1 = m1_cyc_i && (!m0_cyc_i || !last);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      own   <= 1'b0;
      last  <= 1'b1;
      wd    <= '0;
      err_q <= 2'b00;
    end else begin
      err_q <= 2'b00;
      case (state)
        IDLE: begin
          wd <= '0;
          unique case (1'b1)
            g0: begin
              state <= OWN0;
              own   <= 1'b0;
              last  <= 1'b0;
            end
            g1: begin
              state <= OWN1;
              own   <= 1'b1;
              last  <= 1'b1;
            end
            default: ;
          endcase
        end
        OWN0, OWN1: begin
          if (!ocyc) begin
            state <= IDLE;
            wd    <= '0;
          end else if (wd_exp) begin
            state      <= ERR;
            err_q[own] <= 1'b1;
            wd         <= '0;
          end else if (s_ack_i || !ostb) begin
            wd <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ERR: begin
          if (!ocyc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_err_o = err_q[0];
  assign m1_err_o = err_q[1];

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_adr_o  = '0;
    s_dat_o  = 32'h0;
    m0_ack_o = 1'b0;
    m0_dat_o = 32'h0;
    m1_ack_o = 1'b0;
    m1_dat_o = 32'h0;
    gnt_o    = 2'b00;
    case (state)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        gnt_o    = 2'b01;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        gnt_o    = 2'b10;
      end
      ERR: gnt_o = own ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed scenarios plus randomized bursts
// checked against a grant-order and shadow-memory model.
module tb_wb_mem_arbiter;

  logic        sys_clk;
  logic        sys_rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [29:0] m0_adr_i;
  logic [31:0] m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [29:0] m1_adr_i;
  logic [31:0] m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [29:0] s_adr_o;
  logic [31:0] s_dat_o, s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  wb_mem_arbiter dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // memory slave: registered ack after wait_req wait states
  logic [31:0] mem [64];
  logic        auto_ack;
  logic        ack_mode;
  logic        man_ack;
  int          wcnt;
  int          wait_req;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      auto_ack <= 1'b0;
      wcnt     <= 0;
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 0) ? 32'hDEAD8FF1 : 32'h0;
    end else if (!ack_mode && s_cyc_o && s_stb_o && !auto_ack) begin
      if (wcnt >= wait_req) begin
        auto_ack <= 1'b1;
        wcnt     <= 0;
        if (s_we_o)
          for (int b = 0; b < 4; b++)
            if (s_sel_o[b]) mem[s_adr_o[5:0]][8*b +: 8] <= s_dat_o[8*b +: 8];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      auto_ack <= 1'b0;
      wcnt     <= 0;
    end
  end

  assign s_ack_i = ack_mode ? man_ack : auto_ack;
  assign s_dat_i = mem[s_adr_o[5:0]];

  // reference model state
  logic [31:0] exp_mem [64];
  int          model_last;
  int          n_cmp;
  int          n_bad;
  logic        leak;
  logic        early;
  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input int id);
    return (id != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic mack(input int id);
    return (id != 0) ? m1_ack_o : m0_ack_o;
  endfunction

  function automatic logic merr(input int id);
    return (id != 0) ? m1_err_o : m0_err_o;
  endfunction

  function automatic logic [31:0] mdat(input int id);
    return (id != 0) ? m1_dat_o : m0_dat_o;
  endfunction

  task automatic mset(input int id, input logic cyc, input logic stb,
                      input logic we, input logic [3:0] sel,
                      input logic [29:0] adr, input logic [31:0] dat);
    if (id == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
      m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
      m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  task automatic do_reset();
    mset(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    mset(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    ack_mode = 1'b0;
    man_ack  = 1'b0;
    wait_req = 0;
    sys_rst  = 1'b1;
    tick();
    tick();
    sys_rst  = 1'b0;
    model_last = 1;
    for (int i = 0; i < 64; i++)
      exp_mem[i] = (i == 0) ? 32'hDEAD8FF1 : 32'h0;
  endtask

  task automatic xfer_chk(input int id, input logic we,
                          input logic [29:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input string tag,
                          output logic [31:0] rdat);
    logic got;
    got  = 1'b0;
    rdat = 32'h0;
    leak = 1'b0;
    mset(id, 1, 1, we, sel, adr, dat);
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (mack(id)) begin
        got  = 1'b1;
        rdat = mdat(id);
      end
      if (mack(1 - id) || merr(1 - id) || mdat(1 - id) != 32'h0) leak = 1'b1;
      tick();
    end
    mset(id, 1, 0, 0, 4'h0, 30'h0, 32'h0);
    chk({tag, "_ack"}, {31'b0, got}, 32'd1);
    chk({tag, "_iso"}, {31'b0, leak}, 32'd0);
    if (we) exp_mem[adr[5:0]] = merge(exp_mem[adr[5:0]], dat, sel);
    else chk({tag, "_rd"}, rdat, exp_mem[adr[5:0]]);
  endtask

  task automatic own_run(input int id, input string tag);
    int nx;
    logic [31:0] r;
    nx = $urandom_range(1, 2);
    for (int k = 0; k < nx; k++) begin
      wait_req = $urandom_range(0, 3);
      xfer_chk(id, 1'($urandom_range(0, 1)), 30'($urandom_range(0, 31)),
               4'($urandom_range(1, 15)), $urandom, tag, r);
    end
    mset(id, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    #1 chk({tag, "_drop"}, {31'b0, s_cyc_o}, 32'd0);
    tick();
    #1 chk({tag, "_idle"}, {30'b0, gnt_o}, 32'd0);
  endtask

  task automatic contend(input logic [1:0] mask, input string tag);
    int w;
    if (mask == 2'b11) w = (model_last == 1) ? 0 : 1;
    else w = (mask == 2'b01) ? 0 : 1;
    if (mask[0]) mset(0, 1, 0, 0, 4'h0, 30'h0, 32'h0);
    if (mask[1]) mset(1, 1, 0, 0, 4'h0, 30'h0, 32'h0);
    #1 chk({tag, "_pre"}, {30'b0, gnt_o}, 32'd0);
    tick();
    #1 chk({tag, "_g1"}, {30'b0, gnt_o}, {30'b0, onehot(w)});
    model_last = w;
    own_run(w, tag);
    if (mask == 2'b11) begin
      tick();
      #1 chk({tag, "_g2"}, {30'b0, gnt_o}, {30'b0, onehot(1 - w)});
      model_last = 1 - w;
      own_run(1 - w, tag);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sys_rst = 1'b1;
    ack_mode = 1'b0;
    man_ack = 1'b0;
    wait_req = 0;
    mset(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    mset(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    do_reset();

    #1;
    chk("rst_gnt", {30'b0, gnt_o}, 32'd0);
    chk("rst_scyc", {31'b0, s_cyc_o}, 32'd0);
    chk("rst_sstb", {31'b0, s_stb_o}, 32'd0);
    chk("rst_acks", {30'b0, m1_ack_o, m0_ack_o}, 32'd0);
    chk("rst_errs", {30'b0, m1_err_o, m0_err_o}, 32'd0);

    // single m0 read of the preloaded word
    mset(0, 1, 1, 0, 4'hF, 30'h0, 32'h0);
    #1 chk("t1_n_scyc", {31'b0, s_cyc_o}, 32'd0);
    tick();
    #1 chk("t1_gnt", {30'b0, gnt_o}, 32'd1);
    chk("t1_scyc", {31'b0, s_cyc_o}, 32'd1);
    xfer_chk(0, 1'b0, 30'h0, 4'hF, 32'h0, "t1", rd);
    chk("t1_const", rd, 32'hDEAD8FF1);
    mset(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();

    // contention after reset alternates starting with m0
    do_reset();
    contend(2'b11, "t2a");
    contend(2'b11, "t2b");

    // m1 writes while m0 waits, then m0 reads back
    mset(1, 1, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    #1 chk("t3_gnt1", {30'b0, gnt_o}, 32'd2);
    model_last = 1;
    mset(0, 1, 0, 0, 4'h0, 30'h0, 32'h0);
    mset(1, 1, 1, 1, 4'b0011, 30'h10, 32'h12345678);
    #1;
    chk("t3_sadr", {2'b0, s_adr_o}, 32'h10);
    chk("t3_sdat", s_dat_o, 32'h12345678);
    chk("t3_ssel", {28'b0, s_sel_o}, 32'h3);
    chk("t3_swe", {31'b0, s_we_o}, 32'd1);
    xfer_chk(1, 1'b1, 30'h10, 4'b0011, 32'h12345678, "t3_wr", rd);
    mset(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    #1 chk("t3_idle", {30'b0, gnt_o}, 32'd0);
    tick();
    #1 chk("t3_gnt0", {30'b0, gnt_o}, 32'd1);
    model_last = 0;
    xfer_chk(0, 1'b0, 30'h10, 4'hF, 32'h0, "t3_rd", rd);
    chk("t3_const", rd, 32'h00005678);
    mset(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();

    // watchdog expiry on m1 with m0 waiting
    mset(1, 1, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    #1 chk("t4_gnt", {30'b0, gnt_o}, 32'd2);
    model_last = 1;
    ack_mode = 1'b1;
    man_ack = 1'b0;
    mset(0, 1, 0, 0, 4'h0, 30'h0, 32'h0);
    mset(1, 1, 1, 0, 4'hF, 30'h4, 32'h0);
    early = 1'b0;
    repeat (15) begin
      tick();
      #1 if (m1_err_o) early = 1'b1;
    end
    tick();
    #1 chk("t4_err", {31'b0, m1_err_o}, 32'd1);
    chk("t4_early", {31'b0, early}, 32'd0);
    chk("t4_scyc", {31'b0, s_cyc_o}, 32'd0);
    chk("t4_m0err", {31'b0, m0_err_o}, 32'd0);
    tick();
    #1 chk("t4_pulse", {31'b0, m1_err_o}, 32'd0);
    chk("t4_blk", {31'b0, gnt_o[0]}, 32'd0);
    man_ack = 1'b1;
    #1 chk("t4_ackdrop", {31'b0, m1_ack_o}, 32'd0);
    tick();
    man_ack = 1'b0;
    #1 chk("t4_norepulse", {31'b0, m1_err_o}, 32'd0);
    chk("t4_blk2", {30'b0, m0_ack_o, gnt_o[0]}, 32'd0);
    mset(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    #1 chk("t4_idle", {30'b0, gnt_o}, 32'd0);
    tick();
    #1 chk("t4_gnt0", {30'b0, gnt_o}, 32'd1);
    model_last = 0;
    ack_mode = 1'b0;
    wait_req = 0;
    xfer_chk(0, 1'b0, 30'h0, 4'hF, 32'h0, "t4_rd", rd);
    mset(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();

    // ack on the expiry cycle suppresses the error
    mset(0, 1, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    #1 chk("t5_gnt", {30'b0, gnt_o}, 32'd1);
    model_last = 0;
    ack_mode = 1'b1;
    man_ack = 1'b0;
    mset(0, 1, 1, 0, 4'hF, 30'h3, 32'h0);
    early = 1'b0;
    repeat (15) begin
      tick();
      #1 if (m0_err_o) early = 1'b1;
    end
    man_ack = 1'b1;
    #1 chk("t5_ack", {31'b0, m0_ack_o}, 32'd1);
    chk("t5_early", {31'b0, early}, 32'd0);
    tick();
    man_ack = 1'b0;
    #1 chk("t5_noerr", {31'b0, m0_err_o}, 32'd0);
    chk("t5_own", {30'b0, gnt_o}, 32'd1);
    mset(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    ack_mode = 1'b0;

    // reset in the middle of an m0 transfer
    wait_req = 30;
    mset(0, 1, 0, 0, 4'h0, 30'h0, 32'h0);
    tick();
    #1 chk("t6_gnt", {30'b0, gnt_o}, 32'd1);
    mset(0, 1, 1, 0, 4'hF, 30'h5, 32'h0);
    tick();
    sys_rst = 1'b1;
    tick();
    #1 chk("t6_gnt_rst", {30'b0, gnt_o}, 32'd0);
    chk("t6_scyc", {31'b0, s_cyc_o}, 32'd0);
    chk("t6_ack_err", {30'b0, m0_ack_o, m0_err_o}, 32'd0);
    do_reset();
    contend(2'b11, "t6_post");

    for (int it = 0; it < 20; it++)
      contend(2'($urandom_range(1, 3)), "rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
